// File: rtl/hamming_byte_assembler_pkg.sv
package hamming_byte_assembler_pkg;

  // Hamming(7,4) codeword bit positions (position k held in cw[k-1]).
  localparam int unsigned P1_IDX = 0;
  localparam int unsigned P2_IDX = 1;
  localparam int unsigned D1_IDX = 2;
  localparam int unsigned P4_IDX = 3;
  localparam int unsigned D2_IDX = 4;
  localparam int unsigned D3_IDX = 5;
  localparam int unsigned D4_IDX = 6;

  typedef enum logic {
    PAIR_LOW  = 1'b0,
    PAIR_HIGH = 1'b1
  } pair_state_e;

  // Returns {s4,s2,s1}; nonzero value is the 1-based position of a single-bit error.
  function automatic logic [2:0] hamming_syndrome(input logic [6:0] cw);
    logic s1, s2, s4;
    s1 = cw[P1_IDX] ^ cw[D1_IDX] ^ cw[D2_IDX] ^ cw[D4_IDX];
    s2 = cw[P2_IDX] ^ cw[D1_IDX] ^ cw[D3_IDX] ^ cw[D4_IDX];
    s4 = cw[P4_IDX] ^ cw[D2_IDX] ^ cw[D3_IDX] ^ cw[D4_IDX];
    return {s4, s2, s1};
  endfunction

endpackage

// File: rtl/hamming_byte_assembler_decode.sv
module hamming74_decode
  import hamming_byte_assembler_pkg::*;
(
  input  logic [6:0] cw_i,
  output logic [3:0] nibble_o,
  output logic       corrected_o,
  output logic [2:0] syndrome_o
);

  logic [6:0] flip;
  logic [6:0] fixed;

  always_comb begin
    syndrome_o = hamming_syndrome(cw_i);
    flip       = '0;
    for (int unsigned k = 0; k < 7; k++) begin
      flip[k] = (syndrome_o == 3'(k + 1));
    end
    fixed       = cw_i ^ flip;
    corrected_o = |syndrome_o;
    nibble_o    = {fixed[D4_IDX], fixed[D3_IDX], fixed[D2_IDX], fixed[D1_IDX]};
  end

endmodule

// File: rtl/hamming_byte_assembler.sv
module hamming_byte_assembler
  import hamming_byte_assembler_pkg::*;
#(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [6:0]       cw_in,
  input  logic             cw_valid,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic             pending,
  output logic [CNT_W-1:0] corr_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             overflow,
  output logic             timeout_flag,
  input  logic             clear_stats
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [3:0] dec_nibble;
  logic       dec_corrected;
  logic [2:0] dec_syndrome;

  hamming74_decode u_decode (
    .cw_i        (cw_in),
    .nibble_o    (dec_nibble),
    .corrected_o (dec_corrected),
    .syndrome_o  (dec_syndrome)
  );

  logic accept;
  assign accept = cw_valid && ena;

  // Pairing FSM
  pair_state_e state_q, state_d;
  logic [3:0]  low_q, low_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic        push;
  logic [7:0]  push_byte;
  logic        timeout_ev;

  always_comb begin
    state_d    = state_q;
    low_d      = low_q;
    tcnt_d     = tcnt_q;
    push       = 1'b0;
    push_byte  = {dec_nibble, low_q};
    timeout_ev = 1'b0;
    case (state_q)
      PAIR_LOW: begin
        if (accept) begin
          low_d   = dec_nibble;
          tcnt_d  = '0;
          state_d = PAIR_HIGH;
        end
      end
      PAIR_HIGH: begin
        // An accept on the expiry cycle takes priority over the timeout.
        if (accept) begin
          push    = 1'b1;
          tcnt_d  = '0;
          state_d = PAIR_LOW;
        end else if (ena) begin
          if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            timeout_ev = 1'b1;
            tcnt_d     = '0;
            state_d    = PAIR_LOW;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      default: state_d = PAIR_LOW;
    endcase
  end

  // Show-ahead FIFO
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop;
  logic          push_ok;
  logic          overflow_ev;

  always_comb begin
    pop         = (count_q != '0) && byte_ready;
    push_ok     = push && ((count_q < CW'(DEPTH)) || pop);
    overflow_ev = push && !push_ok;
    wr_ptr_d    = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d     = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_byte;
    end
  end

  // Statistics
  logic [CNT_W-1:0] corr_q, corr_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             overflow_q, overflow_d;
  logic             timeout_q, timeout_d;

  always_comb begin
    corr_d     = corr_q;
    drop_d     = drop_q;
    overflow_d = overflow_q | overflow_ev;
    timeout_d  = timeout_q | timeout_ev;
    if (accept && dec_corrected && (corr_q != '1)) begin
      corr_d = corr_q + CNT_W'(1);
    end
    // overflow_ev and timeout_ev are mutually exclusive: push needs an accept, timeout needs none.
    if ((overflow_ev || timeout_ev) && (drop_q != '1)) begin
      drop_d = drop_q + CNT_W'(1);
    end
    if (clear_stats) begin
      corr_d     = '0;
      drop_d     = '0;
      overflow_d = 1'b0;
      timeout_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PAIR_LOW;
      low_q      <= '0;
      tcnt_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      corr_q     <= '0;
      drop_q     <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      if (ena) begin
        state_q <= state_d;
        low_q   <= low_d;
        tcnt_q  <= tcnt_d;
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      corr_q     <= corr_d;
      drop_q     <= drop_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
    end
  end

  assign byte_valid   = (count_q != '0);
  assign byte_out     = byte_valid ? mem_q[rd_ptr_q] : '0;
  assign pending      = (state_q == PAIR_HIGH);
  assign corr_count   = corr_q;
  assign drop_count   = drop_q;
  assign overflow     = overflow_q;
  assign timeout_flag = timeout_q;

endmodule
